count_sequence_checker: RTL

- Sequence monitor on the receiving end of a free-running up-counter's count bus.
- Samples the count whenever `count_valid` is high and predicts the next value (previous + 1, modulo 2^WIDTH).
- Locks after a run of consecutive correct samples; then reports skips, repeats and corruption as errors, and counts wrap-arounds.
- Sits beside the counter in simulation and on-chip as a self-check block.

---
 rtl/count_sequence_checker.sv | 101 ++++++++++
 1 files changed

// File: rtl/count_sequence_checker.sv
// Self-check monitor for a free-running up-counter bus: predicts count+1, locks after
// LOCK_CNT in-sequence samples, then flags and counts mismatches and in-lock wraps.
module count_sequence_checker #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              count_valid,
    input  logic [WIDTH-1:0]  count_in,
    output logic              locked,
    output logic              error_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [WIDTH-1:0]  bad_value
);

    localparam int RUN_W = 8;

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  exp_q, exp_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic [WIDTH-1:0]  bad_q, bad_d;
    logic              pulse_q, pulse_d;

    logic              match;
    logic [RUN_W-1:0]  run_inc;

    assign match   = (count_in == exp_q);
    assign run_inc = match ? run_q + RUN_W'(1) : RUN_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= UNLOCKED;
            exp_q   <= '0;
            run_q   <= '0;
            err_q   <= '0;
            wrap_q  <= '0;
            bad_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            run_q   <= run_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
            bad_q   <= bad_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        run_d   = run_q;
        err_d   = err_q;
        wrap_d  = wrap_q;
        bad_d   = bad_q;
        pulse_d = 1'b0;
        if (count_valid) begin
            exp_d = WIDTH'(count_in + WIDTH'(1));
            unique case (state_q)
                UNLOCKED: begin
                    // Mismatches here only restart the run; they are never errors.
                    run_d = run_inc;
                    if (run_inc == RUN_W'(LOCK_CNT))
                        state_d = LOCKED;
                end
                LOCKED: begin
                    if (match) begin
                        if (count_in == '0)
                            wrap_d = wrap_q + WRAP_W'(1);
                    end else begin
                        pulse_d = 1'b1;
                        if (err_q != '1)
                            err_d = err_q + ERR_W'(1);
                        bad_d   = count_in;
                        state_d = UNLOCKED;
                        run_d   = RUN_W'(1);
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    always_comb begin
        locked      = (state_q == LOCKED);
        error_pulse = pulse_q;
        err_count   = err_q;
        wrap_count  = wrap_q;
        bad_value   = bad_q;
    end

endmodule
